// File: rtl/pipelined_carry_adder.sv
// rtl/pipelined_carry_adder.sv - pipelined add/subtract unit with valid/ready handshake
//
// Purpose: PROC_SIZE-bit add/subtract. The carry chain is cut into STAGES
// chunks of CW = PROC_SIZE/STAGES bits, with one register boundary per chunk.
// Fixed latency of STAGES cycles; one operation per cycle when not stalled.
//
// Ports:
//   clk                 clock, all state on rising edge
//   rst                 synchronous reset, active-high
//   in_valid, in_ready  operand handshake for a, b, sub (sub=1: a-b)
//   out_valid, out_ready result handshake for sum, cout
//   sum, cout           result modulo 2^PROC_SIZE, carry out of MSB (sub: 1 = no borrow)
//   ovf                 signed overflow, present only with PIPELINED_CARRY_ADDER_OVF_EN
//
// Optional feature macro: PIPELINED_CARRY_ADDER_OVF_EN

module pipelined_carry_adder #(
   parameter int PROC_SIZE = 16,
   parameter int STAGES    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PROC_SIZE-1:0] a,
   input  logic [PROC_SIZE-1:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PROC_SIZE-1:0] sum,
   output logic                 cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
   ,
   output logic                 ovf
`endif
);

   localparam int CW = PROC_SIZE / STAGES;

   logic advance;

   // The pipe moves as one unit: a stalled output freezes every stage,
   // bubbles included, so nothing is lost or duplicated.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * CW;
      localparam int HI = (k + 1) * CW;

      // Operand bits from chunk k upward: chunk k is added here, the
      // upper chunks are skewed onward to the following stages.
      logic [PROC_SIZE-LO-1:0] a_src;
      logic [PROC_SIZE-LO-1:0] b_src;
      logic                    cin;
      logic                    vin;
      logic [CW:0]             add_d;
      logic [HI-1:0]           res_d;

      logic                    valid_q;
      logic                    carry_q;
      // Result chunks 0..k travel together (deskew of the lower chunks).
      logic [HI-1:0]           res_q;

      assign add_d = {1'b0, a_src[CW-1:0]} + {1'b0, b_src[CW-1:0]} + {{CW{1'b0}}, cin};

      if (k == 0) begin : g_first
         // Subtract as a + ~b + 1; sub is captured with the operands.
         assign a_src = a;
         assign b_src = sub ? ~b : b;
         assign cin   = sub;
         assign vin   = in_valid;
         assign res_d = add_d[CW-1:0];
      end else begin : g_next
         assign a_src = g_stage[k-1].g_skew.a_q;
         assign b_src = g_stage[k-1].g_skew.b_q;
         assign cin   = g_stage[k-1].carry_q;
         assign vin   = g_stage[k-1].valid_q;
         assign res_d = {add_d[CW-1:0], g_stage[k-1].res_q};
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            res_q   <= '0;
         end else if (advance) begin
            valid_q <= vin;
            carry_q <= add_d[CW];
            res_q   <= res_d;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [PROC_SIZE-HI-1:0] a_q;
         logic [PROC_SIZE-HI-1:0] b_q;

         always_ff @(posedge clk) begin
            if (advance) begin
               a_q <= a_src[PROC_SIZE-LO-1:CW];
               b_q <= b_src[PROC_SIZE-LO-1:CW];
            end
         end
      end

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         logic ovf_q;

         // Carry into the MSB equals a_msb ^ b_eff_msb ^ sum_msb.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= add_d[CW] ^ (a_src[CW-1] ^ b_src[CW-1] ^ add_d[CW-1]);
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[STAGES-1].valid_q;
   assign sum       = g_stage[STAGES-1].res_q;
   assign cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
   assign ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb/tb_pipelined_carry_adder.sv - scoreboard bench for pipelined_carry_adder
`timescale 1ns/1ps

module tb_pipelined_carry_adder;

   localparam int W = 16;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf_obs;

   int vectors     = 0;
   int miscompares = 0;

   // Expected {ovf, cout, sum} in acceptance order.
   logic [W+1:0] exp_q [$];

   always #5 clk = ~clk;

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
   logic ovf;
   assign ovf_obs = ovf;
`else
   assign ovf_obs = 1'b0;
`endif

   pipelined_carry_adder #(.PROC_SIZE(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
      logic [W:0]   wide;
      logic [W-1:0] r;
      logic         c;
      logic         v;
      wide = {1'b0, x} + {1'b0, y};
      if (s) begin
         r = x - y;
         c = (x >= y);
         v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end else begin
         r = wide[W-1:0];
         c = wide[W];
         v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
`ifndef PIPELINED_CARRY_ADDER_OVF_EN
      v = 1'b0;
`endif
      return {v, c, r};
   endfunction

   // One cycle: drive inputs, sample handshake/outputs mid-cycle, step past the edge.
   task automatic tick(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic ts, input logic ordy,
                       output logic acc, output logic fire, output logic [W+1:0] obs);
      in_valid  = iv;
      a         = ta;
      b         = tbv;
      sub       = ts;
      out_ready = ordy;
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      obs  = {ovf_obs, cout, sum};
      if (acc) exp_q.push_back(model(ta, tbv, ts));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      vectors++;
      if ({out_valid, in_ready, cout, sum} !== {1'b0, 1'b1, 1'b0, {W{1'b0}}}) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b rdy=%b c=%b s=%h required v=0 rdy=1 c=0 s=0000",
                  out_valid, in_ready, cout, sum);
      end
   endtask

   task automatic test_single();
      logic acc, fire;
      logic [W+1:0] obs, e;
      int hits = 0;
      int hit_cyc = -1;
      for (int c = 0; c < 10; c++) begin
         tick(c == 0, 16'h0001, 16'h0002, 1'b0, 1'b1, acc, fire, obs);
         if (fire) begin
            hits++;
            hit_cyc = c;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL single_spurious: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL single_result: got %h required %h", obs, e);
               end
            end
         end
      end
      vectors++;
      if (hits != 1 || hit_cyc != S) begin
         miscompares++;
         $display("FAIL single_latency: got %0d outputs at cycle %0d required 1 at cycle %0d",
                  hits, hit_cyc, S);
      end
   endtask

   task automatic test_carry_sub();
      logic [W-1:0] ta  [7] = '{16'hFFFF, 16'h00FF, 16'h0009, 16'h000A, 16'h7FFF, 16'h8000, 16'h7FFF};
      logic [W-1:0] tbv [7] = '{16'h0001, 16'h0001, 16'h000A, 16'h0009, 16'hFFFF, 16'h0001, 16'h0001};
      logic         ts  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic acc, fire;
      logic [W+1:0] obs, e;
      int i = 0;
      int idx;
      for (int c = 0; c < 7 + S + 6; c++) begin
         idx = (i < 7) ? i : 0;
         tick(i < 7, ta[idx], tbv[idx], ts[idx], 1'b1, acc, fire, obs);
         if (acc) i++;
         if (fire) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL carry_sub_spurious: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL carry_sub_result: got %h required %h", obs, e);
               end
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0 || i != 7) begin
         miscompares++;
         $display("FAIL carry_sub_drain: got %0d pending, %0d sent required 0 pending, 7 sent",
                  exp_q.size(), i);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ta  [8] = '{16'h0000, 16'h0001, 16'h0009, 16'h000F, 16'hFFFF, 16'h1234, 16'h8000, 16'h00FF};
      logic [W-1:0] tbv [8] = '{16'h0000, 16'h0002, 16'h000A, 16'h000F, 16'hFFFF, 16'h0FED, 16'h8000, 16'h0F01};
      logic acc, fire;
      logic [W+1:0] obs, e;
      int hits = 0, first = -1, last = -1, accepted = 0;
      for (int c = 0; c < 8 + S + 4; c++) begin
         tick(c < 8, ta[c < 8 ? c : 0], tbv[c < 8 ? c : 0], 1'b0, 1'b1, acc, fire, obs);
         if (acc) accepted++;
         if (fire) begin
            hits++;
            if (first < 0) first = c;
            last = c;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL b2b_spurious: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL b2b_result: got %h required %h", obs, e);
               end
            end
         end
      end
      vectors++;
      if (accepted != 8 || hits != 8 || first != S || last != S + 7) begin
         miscompares++;
         $display("FAIL b2b_stream: got acc=%0d out=%0d cycles %0d..%0d required 8/8 cycles %0d..%0d",
                  accepted, hits, first, last, S, S + 7);
      end
   endtask

   task automatic test_stall();
      logic acc, fire, ordy;
      logic [W+1:0] obs, e, hold;
      logic [W-1:0] ta, tbv;
      int i = 0, got = 0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         ta   = W'(16'h1111 * (i + 1));
         tbv  = W'(16'h0F0F + i * 16'h0101);
         ordy = !(c >= 6 && c <= 10);
         tick(i < 10, ta, tbv, i[0], ordy, acc, fire, obs);
         if (acc) i++;
         if (!ordy) begin
            vectors++;
            if (acc) begin
               miscompares++;
               $display("FAIL stall_in_ready: got in_ready=1 required 0 at cycle %0d", c);
            end
            if (c == 6) hold = obs;
            else begin
               vectors++;
               if ({out_valid, obs} !== {1'b1, hold}) begin
                  miscompares++;
                  $display("FAIL stall_hold: got v=%b %h required v=1 %h", out_valid, obs, hold);
               end
            end
         end
         if (fire) begin
            got++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL stall_spurious: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL stall_result: got %h required %h", obs, e);
               end
            end
         end
      end
      vectors++;
      if (got != 10 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stall_count: got %0d results, %0d pending required 10, 0", got, exp_q.size());
      end
   endtask

   task automatic test_reset_flight();
      logic acc, fire;
      logic [W+1:0] obs;
      int leaks = 0;
      for (int c = 0; c < 3; c++) tick(1'b1, W'(c + 5), W'(c + 7), 1'b0, 1'b1, acc, fire, obs);
      rst = 1'b1;
      tick(1'b0, '0, '0, 1'b0, 1'b1, acc, fire, obs);
      rst = 1'b0;
      exp_q.delete();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flight_reset: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
      end
      for (int c = 0; c < 10; c++) begin
         tick(1'b0, '0, '0, 1'b0, 1'b1, acc, fire, obs);
         if (fire) leaks++;
      end
      vectors++;
      if (leaks != 0) begin
         miscompares++;
         $display("FAIL flight_leak: got %0d stale results required 0", leaks);
      end
   endtask

   task automatic test_random();
      logic acc, fire;
      logic [W+1:0] obs, e;
      for (int c = 0; c < 100; c++) begin
         tick(c < 80 && $urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
              1'($urandom), c >= 80 || $urandom_range(0, 3) != 0, acc, fire, obs);
         if (fire) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL random_spurious: got %h required no output", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL random_result: got %h required %h", obs, e);
               end
            end
         end
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL random_drain: got %0d pending required 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_carry_sub();
      test_back_to_back();
      test_stall();
      test_reset_flight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

endmodule
